// File: rtl/cnn_layer_sequencer.sv
// Layer-engine sequencer: runs enabled engines in index order through start/done
// handshakes with a per-layer watchdog, plus a round-robin host/consumer read arbiter.
module cnn_layer_sequencer #(
    parameter int unsigned NUM_LAYERS     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1048575,
    parameter int unsigned LW             = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  run,
    input  logic                  abort,
    input  logic [NUM_LAYERS-1:0] layer_mask,
    output logic [NUM_LAYERS-1:0] layer_start,
    input  logic [NUM_LAYERS-1:0] layer_done,
    output logic                  busy,
    output logic                  seq_done,
    output logic                  error,
    output logic [1:0]            err_code,
    output logic [LW-1:0]         cur_layer,
    output logic [31:0]           cycle_count,
    input  logic                  host_req,
    input  logic [31:0]           host_addr,
    output logic                  host_ack,
    input  logic                  cons_req,
    input  logic [31:0]           cons_addr,
    output logic                  cons_ack,
    output logic [3:0]            rd_rdata,
    output logic [31:0]           eng_rd_addr,
    input  logic [3:0]            eng_rd_data
);
    localparam int unsigned KW  = $clog2(NUM_LAYERS + 1);
    localparam int unsigned WDW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_TIMEOUT = 2'd1;
    localparam logic [1:0] ERR_ABORT   = 2'd2;

    typedef enum logic [2:0] {S_IDLE, S_SCAN, S_START, S_WAIT, S_FINISH} state_t;
    typedef enum logic [1:0] {A_ARB, A_ADDR, A_DATA} arb_state_t;

    state_t                state_q, state_d;
    logic [KW-1:0]         k_q, k_d;
    logic [NUM_LAYERS-1:0] mask_q, mask_d;
    logic [WDW-1:0]        wd_q, wd_d;
    logic [LW-1:0]         cur_layer_q, cur_layer_d;
    logic                  error_q, error_d;
    logic [1:0]            err_code_q, err_code_d;
    logic [31:0]           cycle_count_q, cycle_count_d;

    arb_state_t            arb_q, arb_d;
    logic                  gnt_host_q, gnt_host_d;
    logic [31:0]           eng_rd_addr_q, eng_rd_addr_d;
    logic [3:0]            rd_rdata_q, rd_rdata_d;

    logic [LW-1:0] k_idx;
    logic          k_at_end, k_enabled, done_k, wd_expired, pick_host;

    assign k_idx      = k_q[LW-1:0];
    assign k_at_end   = (k_q == KW'(NUM_LAYERS));
    assign k_enabled  = !k_at_end && mask_q[k_idx];
    assign done_k     = layer_done[k_idx];
    assign wd_expired = (wd_q == WDW'(TIMEOUT_CYCLES - 1));
    // Round robin: on contention the requester not granted last time wins.
    assign pick_host  = (host_req && cons_req) ? !gnt_host_q : host_req;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q       <= S_IDLE;
            k_q           <= '0;
            mask_q        <= '0;
            wd_q          <= '0;
            cur_layer_q   <= '0;
            error_q       <= 1'b0;
            err_code_q    <= ERR_NONE;
            cycle_count_q <= '0;
            arb_q         <= A_ARB;
            gnt_host_q    <= 1'b1;
            eng_rd_addr_q <= '0;
            rd_rdata_q    <= '0;
        end else begin
            state_q       <= state_d;
            k_q           <= k_d;
            mask_q        <= mask_d;
            wd_q          <= wd_d;
            cur_layer_q   <= cur_layer_d;
            error_q       <= error_d;
            err_code_q    <= err_code_d;
            cycle_count_q <= cycle_count_d;
            arb_q         <= arb_d;
            gnt_host_q    <= gnt_host_d;
            eng_rd_addr_q <= eng_rd_addr_d;
            rd_rdata_q    <= rd_rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q != S_IDLE && abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:   if (run && !abort) state_d = S_SCAN;
                S_SCAN:   if (k_at_end) state_d = S_FINISH;
                          else if (k_enabled) state_d = S_START;
                S_START:  state_d = S_WAIT;
                S_WAIT:   if (done_k) state_d = S_SCAN;
                          else if (wd_expired) state_d = S_IDLE;
                S_FINISH: state_d = S_IDLE;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        k_d           = k_q;
        mask_d        = mask_q;
        wd_d          = wd_q;
        cur_layer_d   = cur_layer_q;
        error_d       = error_q;
        err_code_d    = err_code_q;
        cycle_count_d = cycle_count_q;
        if (state_q == S_IDLE) begin
            if (run && !abort) begin
                mask_d        = layer_mask;
                k_d           = '0;
                error_d       = 1'b0;
                err_code_d    = ERR_NONE;
                cycle_count_d = '0;
            end
        end else begin
            if (cycle_count_q != '1) cycle_count_d = cycle_count_q + 32'd1;
            if (abort) begin
                error_d    = 1'b1;
                err_code_d = ERR_ABORT;
            end else begin
                case (state_q)
                    S_SCAN: begin
                        if (k_enabled) cur_layer_d = k_idx;
                        else if (!k_at_end) k_d = k_q + 1'b1;
                    end
                    S_START: wd_d = '0;
                    S_WAIT: begin
                        if (done_k) begin
                            k_d = k_q + 1'b1;
                        end else if (wd_expired) begin
                            error_d    = 1'b1;
                            err_code_d = ERR_TIMEOUT;
                        end else begin
                            wd_d = wd_q + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        layer_start = '0;
        if (state_q == S_START) layer_start[k_idx] = 1'b1;
        busy        = (state_q != S_IDLE);
        seq_done    = (state_q == S_FINISH);
        error       = error_q;
        err_code    = err_code_q;
        cur_layer   = cur_layer_q;
        cycle_count = cycle_count_q;
    end

    always_comb begin
        arb_d         = arb_q;
        gnt_host_d    = gnt_host_q;
        eng_rd_addr_d = eng_rd_addr_q;
        rd_rdata_d    = rd_rdata_q;
        case (arb_q)
            A_ARB: begin
                if (host_req || cons_req) begin
                    gnt_host_d    = pick_host;
                    eng_rd_addr_d = pick_host ? host_addr : cons_addr;
                    arb_d         = A_ADDR;
                end
            end
            A_ADDR: arb_d = A_DATA;
            A_DATA: begin
                rd_rdata_d = eng_rd_data;
                arb_d      = A_ARB;
            end
            default: arb_d = A_ARB;
        endcase
    end

    // Engine data is only valid while the address is held, so the ack cycle passes it
    // straight through; the captured copy is what rd_rdata shows afterwards.
    always_comb begin
        host_ack    = (arb_q == A_DATA) && gnt_host_q;
        cons_ack    = (arb_q == A_DATA) && !gnt_host_q;
        rd_rdata    = (arb_q == A_DATA) ? eng_rd_data : rd_rdata_q;
        eng_rd_addr = eng_rd_addr_q;
    end
endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Scoreboard bench for cnn_layer_sequencer: engine responder, BRAM-style read port model.
module tb_cnn_layer_sequencer;
    localparam int NL = 4;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          resetn, run, abort;
    logic [NL-1:0] layer_mask, layer_start, layer_done;
    logic          busy, seq_done, error;
    logic [1:0]    err_code;
    logic [1:0]    cur_layer;
    logic [31:0]   cycle_count;
    logic          host_req, cons_req, host_ack, cons_ack;
    logic [31:0]   host_addr, cons_addr, eng_rd_addr;
    logic [3:0]    rd_rdata, eng_rd_data;

    always #5 clk = ~clk;

    cnn_layer_sequencer #(.NUM_LAYERS(NL), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .resetn(resetn), .run(run), .abort(abort),
        .layer_mask(layer_mask), .layer_start(layer_start), .layer_done(layer_done),
        .busy(busy), .seq_done(seq_done), .error(error), .err_code(err_code),
        .cur_layer(cur_layer), .cycle_count(cycle_count),
        .host_req(host_req), .host_addr(host_addr), .host_ack(host_ack),
        .cons_req(cons_req), .cons_addr(cons_addr), .cons_ack(cons_ack),
        .rd_rdata(rd_rdata), .eng_rd_addr(eng_rd_addr), .eng_rd_data(eng_rd_data)
    );

    function automatic logic [3:0] nib(input logic [31:0] a);
        logic [31:0] t;
        t = a * 32'd7 + 32'd3;
        return t[3:0] ^ a[7:4];
    endfunction

    // Engine read port: registered word index plus a live nibble select.
    logic [28:0] bram_word_q = '0;
    always @(posedge clk) bram_word_q <= eng_rd_addr[31:3];
    assign eng_rd_data = nib({bram_word_q, eng_rd_addr[2:0]});

    typedef struct { int layer; int cyc; } ev_t;
    typedef struct { bit host; logic [31:0] addr; logic [3:0] data; } rd_t;
    ev_t exp_q[$];
    rd_t exp_rd[$];

    int n_cmp = 0;
    int n_fail = 0;
    int seq_done_cyc, end_cyc;

    function automatic ev_t mk_ev(input int l, input int c);
        ev_t e;
        e.layer = l;
        e.cyc   = c;
        return e;
    endfunction

    function automatic rd_t mk_rd(input bit h, input logic [31:0] a);
        rd_t r;
        r.host = h;
        r.addr = a;
        r.data = nib(a);
        return r;
    endfunction

    // Pulses run in cycle 0 and plays the engines; starts are checked against exp_q.
    task automatic run_engines(input string tag, input logic [NL-1:0] mask, input int dly,
                               input int hang, input int abort_layer, input int rerun_at,
                               input int max_cyc);
        int  due [NL];
        ev_t e;
        foreach (due[k]) due[k] = -1;
        seq_done_cyc = -1;
        end_cyc      = -1;
        layer_mask   = mask;
        run          = 1'b1;
        for (int c = 1; c <= max_cyc; c++) begin
            @(posedge clk); #1;
            run = 1'b0; abort = 1'b0; layer_done = '0;
            if (seq_done) seq_done_cyc = c;
            for (int k = 0; k < NL; k++) begin
                if (layer_start[k]) begin
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL %s_start: got layer %0d at cycle %0d, expected no start", tag, k, c);
                    end else begin
                        e = exp_q.pop_front();
                        if (k !== e.layer || c !== e.cyc) begin
                            n_fail++;
                            $display("FAIL %s_start: got layer %0d at cycle %0d, expected layer %0d at cycle %0d",
                                     tag, k, c, e.layer, e.cyc);
                        end
                    end
                    if (k != hang) due[k] = c + dly;
                end
            end
            if (!busy) begin
                end_cyc = c;
                break;
            end
            for (int k = 0; k < NL; k++) begin
                if (due[k] == c) begin
                    layer_done[k] = 1'b1;
                    due[k] = -1;
                    if (k == abort_layer) abort = 1'b1;
                end
            end
            if (c == rerun_at) begin
                run = 1'b1;
                layer_mask = '1;
            end
        end
        n_cmp++;
        if (exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL %s_missing: got %0d expected starts not seen, expected 0", tag, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset;
        logic [80:0] snap;
        resetn = 1'b0; run = 1'b0; abort = 1'b0; layer_mask = '0; layer_done = '0;
        host_req = 1'b0; cons_req = 1'b0; host_addr = '0; cons_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        snap = {layer_start, busy, seq_done, error, err_code, cur_layer, cycle_count,
                host_ack, cons_ack, rd_rdata, eng_rd_addr};
        n_cmp++;
        if (snap !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h, expected 0", snap);
        end
        resetn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_full_mask;
        exp_q.push_back(mk_ev(0, 2));
        exp_q.push_back(mk_ev(1, 13));
        exp_q.push_back(mk_ev(2, 24));
        exp_q.push_back(mk_ev(3, 35));
        run_engines("full", 4'b1111, 9, -1, -1, -1, 80);
        n_cmp++; if (seq_done_cyc !== 46) begin n_fail++; $display("FAIL full_seq_done: got cycle %0d, expected 46", seq_done_cyc); end
        n_cmp++; if (end_cyc !== 47) begin n_fail++; $display("FAIL full_busy_end: got cycle %0d, expected 47", end_cyc); end
        n_cmp++; if ({error, err_code} !== 3'b000) begin n_fail++; $display("FAIL full_error: got %b/%0d, expected 0/0", error, err_code); end
        n_cmp++; if (cur_layer !== 2'd3) begin n_fail++; $display("FAIL full_cur_layer: got %0d, expected 3", cur_layer); end
        n_cmp++; if (cycle_count !== 32'd46) begin n_fail++; $display("FAIL full_cycle_count: got %0d, expected 46", cycle_count); end
    endtask

    task automatic test_sparse_mask;
        exp_q.push_back(mk_ev(1, 3));
        exp_q.push_back(mk_ev(3, 15));
        run_engines("sparse", 4'b1010, 9, -1, -1, -1, 60);
        n_cmp++; if (seq_done_cyc !== 26) begin n_fail++; $display("FAIL sparse_seq_done: got cycle %0d, expected 26", seq_done_cyc); end
        n_cmp++; if (cur_layer !== 2'd3) begin n_fail++; $display("FAIL sparse_cur_layer: got %0d, expected 3", cur_layer); end
        n_cmp++; if (error !== 1'b0) begin n_fail++; $display("FAIL sparse_error: got %b, expected 0", error); end
    endtask

    task automatic test_done_at_timeout;
        exp_q.push_back(mk_ev(0, 2));
        run_engines("edge", 4'b0001, TO, -1, -1, -1, 60);
        n_cmp++; if (seq_done_cyc !== 23) begin n_fail++; $display("FAIL edge_seq_done: got cycle %0d, expected 23", seq_done_cyc); end
        n_cmp++; if ({error, err_code} !== 3'b000) begin n_fail++; $display("FAIL edge_error: got %b/%0d, expected 0/0", error, err_code); end
    endtask

    task automatic test_timeout;
        exp_q.push_back(mk_ev(0, 2));
        exp_q.push_back(mk_ev(1, 13));
        exp_q.push_back(mk_ev(2, 24));
        run_engines("tmo", 4'b1111, 9, 2, -1, -1, 80);
        n_cmp++; if (end_cyc !== 41) begin n_fail++; $display("FAIL tmo_busy_end: got cycle %0d, expected 41", end_cyc); end
        n_cmp++; if (seq_done_cyc !== -1) begin n_fail++; $display("FAIL tmo_seq_done: got cycle %0d, expected none", seq_done_cyc); end
        n_cmp++; if ({error, err_code} !== 3'b101) begin n_fail++; $display("FAIL tmo_error: got %b/%0d, expected 1/1", error, err_code); end
        n_cmp++; if (cur_layer !== 2'd2) begin n_fail++; $display("FAIL tmo_cur_layer: got %0d, expected 2", cur_layer); end
    endtask

    task automatic test_abort_with_done;
        exp_q.push_back(mk_ev(0, 2));
        exp_q.push_back(mk_ev(1, 13));
        run_engines("abort", 4'b1111, 9, -1, 1, -1, 60);
        n_cmp++; if (end_cyc !== 23) begin n_fail++; $display("FAIL abort_busy_end: got cycle %0d, expected 23", end_cyc); end
        n_cmp++; if (seq_done_cyc !== -1) begin n_fail++; $display("FAIL abort_seq_done: got cycle %0d, expected none", seq_done_cyc); end
        n_cmp++; if ({error, err_code} !== 3'b110) begin n_fail++; $display("FAIL abort_error: got %b/%0d, expected 1/2", error, err_code); end
        repeat (4) begin
            @(posedge clk); #1;
            n_cmp++; if (layer_start !== '0) begin n_fail++; $display("FAIL abort_late_start: got %b, expected 0", layer_start); end
        end
    endtask

    task automatic test_zero_mask_and_busy_run;
        run_engines("zero", 4'b0000, 9, -1, -1, 3, 30);
        n_cmp++; if (seq_done_cyc !== 6) begin n_fail++; $display("FAIL zero_seq_done: got cycle %0d, expected 6", seq_done_cyc); end
        n_cmp++; if ({error, err_code} !== 3'b000) begin n_fail++; $display("FAIL zero_error: got %b/%0d, expected 0/0", error, err_code); end
        n_cmp++; if (cycle_count !== 32'd6) begin n_fail++; $display("FAIL zero_cycle_count: got %0d, expected 6", cycle_count); end
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (cycle_count !== 32'd6) begin n_fail++; $display("FAIL zero_count_hold: got %0d, expected 6", cycle_count); end
    endtask

    task automatic test_arbiter_alternate;
        rd_t e;
        int  cyc = 0;
        int  last_ack = -1;
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) exp_rd.push_back(mk_rd(1'b0, 32'd12));
            else            exp_rd.push_back(mk_rd(1'b1, 32'd5));
        end
        cons_addr = 32'd12; host_addr = 32'd5;
        cons_req = 1'b1; host_req = 1'b1;
        while (exp_rd.size() > 0 && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
            if (host_ack || cons_ack) begin
                e = exp_rd.pop_front();
                n_cmp++;
                if (host_ack !== e.host || cons_ack !== !e.host || rd_rdata !== e.data || eng_rd_addr !== e.addr) begin
                    n_fail++;
                    $display("FAIL arb_alt: got host_ack=%b cons_ack=%b data=%h addr=%0d, expected host=%b data=%h addr=%0d",
                             host_ack, cons_ack, rd_rdata, eng_rd_addr, e.host, e.data, e.addr);
                end
                if (last_ack >= 0) begin
                    n_cmp++;
                    if (cyc - last_ack !== 3) begin n_fail++; $display("FAIL arb_pitch: got %0d cycles, expected 3", cyc - last_ack); end
                end
                last_ack = cyc;
            end
        end
        n_cmp++;
        if (exp_rd.size() !== 0) begin
            n_fail++;
            $display("FAIL arb_alt_timeout: got %0d reads outstanding, expected 0", exp_rd.size());
            exp_rd.delete();
        end
        host_req = 1'b0; cons_req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_arbiter_addr_change;
        rd_t e;
        int  cyc = 0;
        int  left = 4;
        host_addr = $urandom;
        exp_rd.push_back(mk_rd(1'b1, host_addr));
        host_req = 1'b1;
        while (exp_rd.size() > 0 && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
            if (host_ack || cons_ack) begin
                e = exp_rd.pop_front();
                n_cmp++;
                if (host_ack !== 1'b1 || rd_rdata !== e.data || eng_rd_addr !== e.addr) begin
                    n_fail++;
                    $display("FAIL arb_host: got host_ack=%b data=%h addr=%h, expected 1 data=%h addr=%h",
                             host_ack, rd_rdata, eng_rd_addr, e.data, e.addr);
                end
                left--;
                if (left > 0) begin
                    host_addr = $urandom;
                    exp_rd.push_back(mk_rd(1'b1, host_addr));
                end else begin
                    host_req = 1'b0;
                end
            end
        end
        n_cmp++;
        if (exp_rd.size() !== 0) begin
            n_fail++;
            $display("FAIL arb_host_timeout: got %0d reads outstanding, expected 0", exp_rd.size());
            exp_rd.delete();
        end
        host_req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midop;
        logic [80:0] snap;
        bit          saw_ack = 1'b0;
        layer_mask = 4'b1111; run = 1'b1;
        @(posedge clk); #1;
        run = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        host_addr = 32'h33; host_req = 1'b1;
        @(posedge clk); #1;
        resetn = 1'b0; host_req = 1'b0;
        @(posedge clk); #1;
        snap = {layer_start, busy, seq_done, error, err_code, cur_layer, cycle_count,
                host_ack, cons_ack, rd_rdata, eng_rd_addr};
        n_cmp++;
        if (snap !== '0) begin n_fail++; $display("FAIL midreset_outputs: got %h, expected 0", snap); end
        resetn = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            if (host_ack || cons_ack || busy) saw_ack = 1'b1;
        end
        n_cmp++;
        if (saw_ack !== 1'b0) begin n_fail++; $display("FAIL midreset_quiet: got ack/busy activity, expected none"); end
        exp_q.push_back(mk_ev(0, 2));
        run_engines("post_reset", 4'b0001, 9, -1, -1, -1, 40);
        n_cmp++; if (seq_done_cyc !== 16) begin n_fail++; $display("FAIL post_reset_seq_done: got cycle %0d, expected 16", seq_done_cyc); end
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: bench did not finish, expected completion");
        $fatal(1, "bench time limit");
    end

    initial begin
        test_reset();
        test_full_mask();
        test_sparse_mask();
        test_done_at_timeout();
        test_timeout();
        test_abort_with_done();
        test_zero_mask_and_busy_run();
        test_arbiter_alternate();
        test_arbiter_addr_change();
        test_reset_midop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
